// File: rtl/fsm_pattern_tx.sv
// fsm_pattern_tx
//   Serial pattern transmitter for the 3-state (Start/Midway/Done) pattern
//   detector. Each frame is three bits: marker 1, mid bit, fire bit. A burst
//   request (frame count + fire mask) is taken over a valid/ready handshake.
//   The frames of a burst are serialized with GAP_CYCLES idle cycles between
//   them.
//
// Ports
//   i_clock         rising-edge clock
//   i_reset         synchronous, active-high reset
//   i_req_valid     burst request valid
//   o_req_ready     high while IDLE; transfer = valid & ready at a rising edge
//   i_req_len       frames in the burst (0 = empty burst, > NFR clamps to NFR)
//   i_fire_mask     fire bit per frame, bit 0 sent first
//   o_dout          serial pattern line (registered)
//   o_busy          high in any state except IDLE
//   o_frame_strobe  high during each fire-bit cycle
//   o_req_done      one-cycle pulse in the first IDLE cycle after a burst
//   o_frames_total  saturating count of completed frames
module fsm_pattern_tx #(
    parameter int   NFR        = 4,
    parameter int   GAP_CYCLES = 2,
    parameter logic MID_BIT    = 1'b0
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_req_valid,
    output logic           o_req_ready,
    input  logic [2:0]     i_req_len,
    input  logic [NFR-1:0] i_fire_mask,
    output logic           o_dout,
    output logic           o_busy,
    output logic           o_frame_strobe,
    output logic           o_req_done,
    output logic [15:0]    o_frames_total
);

    localparam logic [2:0] NFR_L = 3'(NFR);
    localparam int         CW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // Counter preload: GAP is left when the counter reaches 0, so
    // GAP_CYCLES-1 gives exactly GAP_CYCLES cycles in GAP.
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_MID,
        S_FINAL,
        S_GAP
    } state_t;

    state_t          r_state;
    logic [2:0]      r_len;
    logic [2:0]      r_idx;
    logic [NFR-1:0]  r_mask;
    logic [CW-1:0]   r_gap_cnt;
    logic            r_dout;
    logic            r_strobe;
    logic            r_done;
    logic [15:0]     r_frames_total;

    logic [2:0]      w_len_clamp;

    assign w_len_clamp = (i_req_len > NFR_L) ? NFR_L : i_req_len;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_len          <= '0;
            r_idx          <= '0;
            r_mask         <= '0;
            r_gap_cnt      <= '0;
            r_dout         <= 1'b0;
            r_strobe       <= 1'b0;
            r_done         <= 1'b0;
            r_frames_total <= '0;
        end else begin
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_dout <= 1'b0;
                    if (i_req_valid) begin
                        r_len  <= w_len_clamp;
                        r_mask <= i_fire_mask;
                        r_idx  <= '0;
                        if (w_len_clamp != 3'd0) begin
                            r_state <= S_MARK;
                            r_dout  <= 1'b1;
                        end else begin
                            // Empty burst: completes without leaving IDLE.
                            r_done <= 1'b1;
                        end
                    end
                end
                S_MARK: begin
                    r_state <= S_MID;
                    r_dout  <= MID_BIT;
                end
                S_MID: begin
                    // Mask is consumed LSB-first; bit 0 is the current frame.
                    r_state  <= S_FINAL;
                    r_dout   <= r_mask[0];
                    r_strobe <= 1'b1;
                end
                S_FINAL: begin
                    if (r_frames_total != 16'hFFFF)
                        r_frames_total <= r_frames_total + 16'd1;
                    r_mask <= r_mask >> 1;
                    if (r_idx == r_len - 3'd1) begin
                        r_state <= S_IDLE;
                        r_dout  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                        if (GAP_CYCLES > 0) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= GAP_LAST;
                            r_dout    <= 1'b0;
                        end else begin
                            r_state <= S_MARK;
                            r_dout  <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= S_MARK;
                        r_dout  <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                        r_dout    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_dout  <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready    = (r_state == S_IDLE);
    assign o_busy         = (r_state != S_IDLE);
    assign o_dout         = r_dout;
    assign o_frame_strobe = r_strobe;
    assign o_req_done     = r_done;
    assign o_frames_total = r_frames_total;

endmodule

// File: tb/tb_fsm_pattern_tx.sv
// Bench for fsm_pattern_tx (NFR=4, GAP_CYCLES=2, MID_BIT=0).
// The expected line is rebuilt per burst as a list of (dout, strobe) cycles.
// A small detector model then counts fire pulses on the observed line.
module tb_fsm_pattern_tx;

    localparam int NFR = 4;
    localparam int GAP = 2;
    localparam logic MIDB = 1'b0;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [2:0]     req_len;
    logic [NFR-1:0] fire_mask;
    logic           dout;
    logic           busy;
    logic           strobe;
    logic           req_done;
    logic [15:0]    frames_total;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_total = 0;

    fsm_pattern_tx #(.NFR(NFR), .GAP_CYCLES(GAP), .MID_BIT(MIDB)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_len      (req_len),
        .i_fire_mask    (fire_mask),
        .o_dout         (dout),
        .o_busy         (busy),
        .o_frame_strobe (strobe),
        .o_req_done     (req_done),
        .o_frames_total (frames_total)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Quiet IDLE cycles following a completed burst.
    task automatic idle(input int k);
        for (int j = 0; j < k; j++) begin
            tick();
            chk("idle_done", 32'(req_done), 32'd0);
            chk("idle_ready", 32'(req_ready), 32'd1);
            chk("idle_dout", 32'(dout), 32'd0);
        end
    endtask

    // Issue one request in the current cycle and follow it to its Req_done
    // cycle (where the task returns). With hold set, valid stays high carrying
    // the next request so it is taken in the Req_done cycle.
    task automatic run_burst(input int len, input logic [NFR-1:0] mask,
                             input bit hold, input int nlen, input logic [NFR-1:0] nmask);
        int   n;
        int   fires;
        int   st;
        int   det;
        logic ed[$];
        logic es[$];
        logic rec[$];
        n = (len > NFR) ? NFR : len;
        fires = 0;
        for (int k = 0; k < n; k++) begin
            ed.push_back(1'b1);    es.push_back(1'b0);
            ed.push_back(MIDB);    es.push_back(1'b0);
            ed.push_back(mask[k]); es.push_back(1'b1);
            if (mask[k]) fires++;
            if (k < n - 1)
                for (int g = 0; g < GAP; g++) begin
                    ed.push_back(1'b0); es.push_back(1'b0);
                end
        end
        req_valid = 1'b1;
        req_len   = 3'(len);
        fire_mask = mask;
        tick();
        if (hold) begin
            req_len   = 3'(nlen);
            fire_mask = nmask;
        end else begin
            req_valid = 1'b0;
        end
        for (int c = 0; c < ed.size(); c++) begin
            chk("dout", 32'(dout), 32'(ed[c]));
            chk("strobe", 32'(strobe), 32'(es[c]));
            chk("busy", 32'(busy), 32'd1);
            chk("ready_busy", 32'(req_ready), 32'd0);
            chk("done_early", 32'(req_done), 32'd0);
            rec.push_back(dout);
            tick();
        end
        exp_total = (exp_total + n > 65535) ? 65535 : exp_total + n;
        chk("done_pulse", 32'(req_done), 32'd1);
        chk("done_ready", 32'(req_ready), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_dout", 32'(dout), 32'd0);
        chk("done_strobe", 32'(strobe), 32'd0);
        chk("frames_total", 32'(frames_total), 32'(exp_total));
        // Detector: a 1 in Start begins a frame; its third bit is the output.
        st = 0;
        det = 0;
        foreach (rec[j]) begin
            if (st == 0) begin
                if (rec[j]) st = 1;
            end else if (st == 1) begin
                st = 2;
            end else begin
                if (rec[j]) det++;
                st = 0;
            end
        end
        chk("detector_fires", 32'(det), 32'(fires));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_len   = '0;
        fire_mask = '0;
        tick();
        tick();
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_done", 32'(req_done), 32'd0);
        chk("rst_strobe", 32'(strobe), 32'd0);
        chk("rst_total", 32'(frames_total), 32'd0);
        rst = 1'b0;

        // Single frame, then a 3-frame burst with frame 1 silent.
        run_burst(1, 4'b0001, 1'b0, 0, '0);
        idle(1);
        run_burst(3, 4'b0101, 1'b0, 0, '0);
        idle(2);

        // Empty burst and clamp of an oversized length.
        run_burst(0, 4'b1111, 1'b0, 0, '0);
        idle(1);
        run_burst(7, 4'b1011, 1'b0, 0, '0);
        idle(1);

        // Reset during the MID cycle of frame 1 of a 3-frame burst.
        req_valid = 1'b1;
        req_len   = 3'd3;
        fire_mask = 4'b0111;
        tick();
        req_valid = 1'b0;
        repeat (6) tick();
        chk("pre_rst_mid", 32'(dout), 32'(MIDB));
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_total = 0;
        chk("abort_dout", 32'(dout), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(req_done), 32'd0);
        chk("abort_total", 32'(frames_total), 32'd0);
        run_burst(2, 4'b0010, 1'b0, 0, '0);
        idle(1);

        // Back-to-back: the second request is held valid through the first.
        run_burst(2, 4'b0011, 1'b1, 3, 4'b0110);
        run_burst(3, 4'b0110, 1'b0, 0, '0);
        idle(1);

        // Random bursts, sometimes chained straight from the Req_done cycle.
        for (int r = 0; r < 12; r++) begin
            int rl;
            logic [NFR-1:0] rm;
            rl = int'($urandom_range(0, 7));
            rm = NFR'($urandom);
            run_burst(rl, rm, 1'b0, 0, '0);
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(1);

        // Saturation of the frame counter.
        force dut.r_frames_total = 16'hFFFE;
        tick();
        release dut.r_frames_total;
        exp_total = 65534;
        chk("preload_total", 32'(frames_total), 32'hFFFE);
        run_burst(3, 4'b0101, 1'b0, 0, '0);
        idle(1);
        run_burst(2, 4'b0011, 1'b0, 0, '0);
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
